// File: rtl/i2cs_rx_ctrl.sv
// i2cs_rx_ctrl: I2C target-side write receiver.
// Oversamples SCL/SDA in the clk domain, detects START/STOP, shifts in the
// address byte and data bytes MSB-first, ACKs a matching write address and
// ACKs data bytes when the sink is ready.
//
// Ports:
//   clk, rst_n   system clock, asynchronous active-low reset
//   i_scl, i_sda asynchronous pad inputs
//   i_rx_rdy     sink can accept a byte (sampled at the ACK decision)
//   o_sda_oe     1 = pull SDA low (ACK)
//   o_data       last received data byte
//   o_data_vld   one-cycle pulse, o_data valid and ACKed
//   o_busy       addressed transaction in progress
//   o_start_pls  one-cycle pulse per START / repeated START
//   o_stop_pls   one-cycle pulse per STOP
module i2cs_rx_ctrl #(
    parameter logic [6:0]  SLV_ADDR = 7'h50,
    parameter int unsigned SYNC_STG = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_scl,
    input  logic       i_sda,
    input  logic       i_rx_rdy,
    output logic       o_sda_oe,
    output logic [7:0] o_data,
    output logic       o_data_vld,
    output logic       o_busy,
    output logic       o_start_pls,
    output logic       o_stop_pls
);

    typedef enum logic [2:0] {
        StIdle, StAddr, StAddrAck, StData, StDataAck, StIgnore
    } state_t;

    state_t              r_state, w_state_nx;
    logic [SYNC_STG-1:0] r_scl_sync, r_sda_sync;
    logic                r_scl_d, r_sda_d;
    logic [2:0]          r_bit_cnt, w_bit_cnt_nx;
    logic [7:0]          r_shift, w_shift_nx;
    logic                r_byte_done, w_byte_done_nx;
    logic                r_sda_oe, w_sda_oe_nx;
    logic [7:0]          r_data, w_data_nx;
    logic                r_vld, w_vld_nx;
    logic                r_busy, w_busy_nx;
    logic                r_start, w_start_nx;
    logic                r_stop, w_stop_nx;

    logic w_scl_s, w_sda_s;
    logic w_scl_rise, w_scl_fall, w_start, w_stop;

    assign w_scl_s    = r_scl_sync[SYNC_STG-1];
    assign w_sda_s    = r_sda_sync[SYNC_STG-1];
    assign w_scl_rise = w_scl_s & ~r_scl_d;
    assign w_scl_fall = ~w_scl_s & r_scl_d;
    // Requiring SCL high in both samples suppresses START/STOP when SCL and SDA
    // move in the same sample; the SCL edge is then processed instead.
    assign w_start    = w_scl_s & r_scl_d & ~w_sda_s & r_sda_d;
    assign w_stop     = w_scl_s & r_scl_d & w_sda_s & ~r_sda_d;

    // Synchronizers reset high: idle bus.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scl_sync <= '1;
            r_sda_sync <= '1;
            r_scl_d    <= 1'b1;
            r_sda_d    <= 1'b1;
        end else begin
            r_scl_sync <= {r_scl_sync[SYNC_STG-2:0], i_scl};
            r_sda_sync <= {r_sda_sync[SYNC_STG-2:0], i_sda};
            r_scl_d    <= w_scl_s;
            r_sda_d    <= w_sda_s;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StIdle;
            r_bit_cnt   <= 3'd0;
            r_shift     <= 8'h00;
            r_byte_done <= 1'b0;
            r_sda_oe    <= 1'b0;
            r_data      <= 8'h00;
            r_vld       <= 1'b0;
            r_busy      <= 1'b0;
            r_start     <= 1'b0;
            r_stop      <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_bit_cnt   <= w_bit_cnt_nx;
            r_shift     <= w_shift_nx;
            r_byte_done <= w_byte_done_nx;
            r_sda_oe    <= w_sda_oe_nx;
            r_data      <= w_data_nx;
            r_vld       <= w_vld_nx;
            r_busy      <= w_busy_nx;
            r_start     <= w_start_nx;
            r_stop      <= w_stop_nx;
        end
    end

    always_comb begin
        w_state_nx     = r_state;
        w_bit_cnt_nx   = r_bit_cnt;
        w_shift_nx     = r_shift;
        w_byte_done_nx = r_byte_done;
        w_sda_oe_nx    = r_sda_oe;
        w_data_nx      = r_data;
        w_vld_nx       = 1'b0;
        w_start_nx     = 1'b0;
        w_stop_nx      = 1'b0;

        if (w_start) begin
            w_start_nx     = 1'b1;
            w_bit_cnt_nx   = 3'd0;
            w_byte_done_nx = 1'b0;
            w_sda_oe_nx    = 1'b0;
            w_state_nx     = StAddr;
        end else if (w_stop) begin
            // Any partial byte is simply dropped.
            w_stop_nx      = 1'b1;
            w_bit_cnt_nx   = 3'd0;
            w_byte_done_nx = 1'b0;
            w_sda_oe_nx    = 1'b0;
            w_state_nx     = StIdle;
        end else begin
            case (r_state)
                StAddr, StData: begin
                    if (w_scl_rise) begin
                        w_shift_nx = {r_shift[6:0], w_sda_s};
                        if (r_bit_cnt == 3'd7) begin
                            w_byte_done_nx = 1'b1;
                            w_bit_cnt_nx   = 3'd0;
                            if (r_state == StData) begin
                                w_data_nx = {r_shift[6:0], w_sda_s};
                            end
                        end else begin
                            w_bit_cnt_nx = r_bit_cnt + 3'd1;
                        end
                    end else if (w_scl_fall && r_byte_done) begin
                        // Fall ending bit 8: drive the ACK bit or give up.
                        w_byte_done_nx = 1'b0;
                        if (r_state == StAddr) begin
                            if (r_shift[7:1] == SLV_ADDR && !r_shift[0]) begin
                                w_sda_oe_nx = 1'b1;
                                w_state_nx  = StAddrAck;
                            end else begin
                                w_state_nx  = StIgnore;
                            end
                        end else if (i_rx_rdy) begin
                            w_sda_oe_nx = 1'b1;
                            w_vld_nx    = 1'b1;
                            w_state_nx  = StDataAck;
                        end else begin
                            w_state_nx  = StIgnore;
                        end
                    end
                end
                StAddrAck, StDataAck: begin
                    if (w_scl_fall) begin
                        w_sda_oe_nx  = 1'b0;
                        w_bit_cnt_nx = 3'd0;
                        w_state_nx   = StData;
                    end
                end
                default: ;
            endcase
        end

        w_busy_nx = (w_state_nx != StIdle) && (w_state_nx != StIgnore);
    end

    assign o_sda_oe    = r_sda_oe;
    assign o_data      = r_data;
    assign o_data_vld  = r_vld;
    assign o_busy      = r_busy;
    assign o_start_pls = r_start;
    assign o_stop_pls  = r_stop;

endmodule

// File: doc/i2cs_rx_ctrl.md
# i2cs_rx_ctrl

I2C target-side write receiver: the far end of the master's parallel-to-serial transmit path. It oversamples SCL/SDA in the clk domain, detects START and STOP, and shifts in the address byte and data bytes MSB-first. It ACKs a matching write address and ACKs data when the downstream sink is ready, presenting each received byte with a one-cycle valid pulse. It sits between the open-drain pad logic and a byte-wide register/FIFO sink.

## Interface
- SLV_ADDR, 7'h50, 7-bit target address this block responds to.
- SYNC_STG, 2, number of synchronizer flops on i_scl/i_sda (≥2).

- clk  input  1  system clock; must be ≥10× SCL frequency.
- rst_n  input  1  reset rst_n, asynchronous, active-low; clock clk.
- i_scl  input  1  SCL pad input (asynchronous).
- i_sda  input  1  SDA pad input (asynchronous).
- i_rx_rdy  input  1  sink can accept a byte; sampled at ACK decision.
- o_sda_oe  output  1  1 = pull SDA low (ACK); 0 = release.
- o_data  output  8  last received data byte.
- o_data_vld  output  1  one-cycle pulse, o_data valid.
- o_busy  output  1  addressed transaction in progress (state ≠ IDLE/IGNORE).
- o_start_pls  output  1  one-cycle pulse per START/repeated START.
- o_stop_pls  output  1  one-cycle pulse per STOP.

## Operation
- Synchronize i_scl/i_sda through SYNC_STG flops; keep one further delayed copy (scl_d, sda_d) for edge detection.
- scl_rise = scl_s & ~scl_d; scl_fall = ~scl_s & scl_d.
- START = scl_s & scl_d & ~sda_s & sda_d; STOP = scl_s & scl_d & sda_s & ~sda_d. START/STOP are checked before SCL edges.
- SDA is sampled on scl_rise into an 8-bit left-shift register (bit 0 ← sda_s); 3-bit counter bit_cnt counts 0..7.
- States:
  - IDLE: wait for START → ADDR.
  - ADDR: shift 8 bits. On the scl_fall after bit 7: if shift[7:1]==SLV_ADDR and shift[0]==0, then o_sda_oe←1 → ADDR_ACK; else → IGNORE with o_sda_oe held 0.
  - ADDR_ACK: on the next scl_fall, o_sda_oe←0, bit_cnt←0 → DATA.
  - DATA: shift 8 bits. On the 8th scl_rise, o_data←shifted byte. On the following scl_fall, sample i_rx_rdy: if 1, o_sda_oe←1 and pulse o_data_vld → DATA_ACK; if 0, o_sda_oe stays 0 (NACK), no vld → IGNORE.
  - DATA_ACK: on the next scl_fall, o_sda_oe←0, bit_cnt←0 → DATA.
  - IGNORE: wait for START or STOP.
- START in any state: o_start_pls, bit_cnt←0, o_sda_oe←0 → ADDR (repeated START).
- STOP in any state: o_stop_pls, o_sda_oe←0 → IDLE; a partial byte is discarded with no vld.
- Read requests (R/W=1) are NACKed; this block does not transmit.

## Timing
- Reset values: o_sda_oe=0, o_data=8'h00, o_data_vld=0, o_busy=0, o_start_pls=0, o_stop_pls=0, state=IDLE, bit_cnt=0, synchronizers=1 (bus idle high).
- Pin-to-detect latency is SYNC_STG+1 clk; all outputs are registered, adding 1 clk more.
- o_sda_oe asserts 1 clk after the detected SCL fall that ends bit 8 and deasserts 1 clk after the detected SCL fall that ends the ACK bit. SDA therefore changes only while SCL is low.
- o_data_vld is high for exactly 1 clk, in the same cycle o_sda_oe rises for a data ACK. o_data is stable from the 8th scl_rise until the next byte completes.
- If SCL and SDA change in the same sample, no START/STOP is flagged and the SCL edge is processed.
- Async reset mid-byte immediately releases SDA and returns the block to IDLE; the next transaction requires a START.

## Test plan
- START, 0xA0 (addr 0x50 W), 0xA5, STOP with i_rx_rdy=1 → ACK on both bytes; o_data=0xA5 with one vld pulse; one o_start_pls and one o_stop_pls.
- START, 0xA2 (addr 0x51), 0x3C → o_sda_oe never asserts, no vld, o_busy=0 after the address byte.
- START, 0xA1 (read) → NACK; block in IGNORE until STOP; o_sda_oe stays 0.
- Address 0xA0, then data 0x11 with i_rx_rdy=1, then data 0x22 with i_rx_rdy=0 → 0x11 ACKed with vld; 0x22 NACKed with no vld; following bytes ignored until STOP.
- Address 0xA0, 4 data bits, repeated START, 0xA0, 0x7E → partial byte dropped; o_start_pls twice; single vld with o_data=0x7E.
- rst_n asserted during the ACK bit → o_sda_oe=0 asynchronously; a post-reset transfer of 0xA0, 0x5A → normal ACK and o_data=0x5A.
